// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - 2-way set-associative write-through, no-write-allocate data cache
// Define ARM_DCACHE_EN to enable caching; without it every access passes through to SRAM.
module dcache_controller #(
  parameter int SET_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 17 - SET_BITS;
`ifdef ARM_DCACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [SETS-1:0]     valid_q [2];
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag_q [2][SETS];
  logic [31:0]         data_q [2][SETS];

  logic [SET_BITS-1:0] idx_in, idx_lat, set_sel;
  logic [TAG_W-1:0]    tag_in, tag_lat;
  logic                hit0, hit1, hit, hit_way, fill_way;
  logic                fill_en, data_en, lru_en, lru_val, way_sel;
  logic [31:0]         hit_data, data_val;

  assign idx_in   = address[SET_BITS+1:2];
  assign tag_in   = address[18:SET_BITS+2];
  assign idx_lat  = addr_q[SET_BITS+1:2];
  assign tag_lat  = addr_q[18:SET_BITS+2];
  assign hit0     = CACHE_EN && valid_q[0][idx_in] && (tag_q[0][idx_in] == tag_in);
  assign hit1     = CACHE_EN && valid_q[1][idx_in] && (tag_q[1][idx_in] == tag_in);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_data = hit1 ? data_q[1][idx_in] : data_q[0][idx_in];
  // Prefer an empty way; only evict the LRU way once both are valid.
  assign fill_way = !valid_q[0][idx_lat] ? 1'b0 :
                    (!valid_q[1][idx_lat] ? 1'b1 : lru_q[idx_lat]);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ready        = 1'b1;
    rdata        = '0;
    sram_rd_en   = 1'b0;
    sram_wr_en   = 1'b0;
    sram_address = addr_q;
    sram_wdata   = wdata_q;
    fill_en      = 1'b0;
    data_en      = 1'b0;
    lru_en       = 1'b0;
    lru_val      = 1'b0;
    way_sel      = 1'b0;
    set_sel      = idx_in;
    data_val     = wdata;
    case (state_q)
      IDLE: begin
        sram_address = address;
        sram_wdata   = wdata;
        if (wr_en) begin
          ready      = 1'b0;
          sram_wr_en = 1'b1;
          addr_d     = address;
          wdata_d    = wdata;
          state_d    = WR_THRU;
          if (hit) begin
            data_en = 1'b1;
            way_sel = hit_way;
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end
        end else if (rd_en) begin
          if (hit) begin
            rdata   = hit_data;
            lru_en  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            ready      = 1'b0;
            sram_rd_en = 1'b1;
            addr_d     = address;
            state_d    = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        sram_rd_en = 1'b1;
        ready      = sram_ready;
        set_sel    = idx_lat;
        data_val   = sram_rdata;
        if (sram_ready) begin
          rdata   = sram_rdata;
          state_d = IDLE;
          fill_en = CACHE_EN;
          way_sel = fill_way;
          lru_en  = CACHE_EN;
          lru_val = ~fill_way;
        end
      end
      WR_THRU: begin
        sram_wr_en = 1'b1;
        ready      = sram_ready;
        if (sram_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (fill_en) valid_q[way_sel][set_sel] <= 1'b1;
      if (lru_en) lru_q[set_sel] <= lru_val;
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) tag_q[way_sel][set_sel] <= tag_lat;
    if (fill_en || data_en) data_q[way_sel][set_sel] <= data_val;
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller with a recency-list reference model
// Honours ARM_DCACHE_EN the same way as the design.
module tb_dcache_controller;
`ifdef ARM_DCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [31:0] rdata, sram_address, sram_wdata;
  logic        ready, sram_rd_en, sram_wr_en;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;

  dcache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_rd_en(sram_rd_en),
    .sram_wr_en(sram_wr_en), .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int unsigned w);
    return w * 32'h9E3779B1 + 32'h0000_1234;
  endfunction

  // SRAM controller model: completion in the 6th consecutive request cycle.
  logic [31:0] sram_mem [int unsigned];
  int seen = 0;
  always @(negedge clk) begin
    if (!rst || !(sram_rd_en || sram_wr_en)) begin
      seen       = 0;
      sram_ready = 1'b0;
    end else begin
      seen++;
      sram_ready = (seen == 6);
      sram_rdata = sram_mem.exists(sram_address >> 2) ? sram_mem[sram_address >> 2]
                                                       : init_val(sram_address >> 2);
      if (sram_ready) begin
        seen = 0;
        if (sram_wr_en) sram_mem[sram_address >> 2] = sram_wdata;
      end
    end
  end

  // Reference: memory contents plus, per set, a recency list of cached word addresses (MRU first).
  logic [31:0] ref_mem [int unsigned];
  int unsigned lines [64][$];

  function automatic logic [31:0] ref_read(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_rd;
    bit          exp_wr;
    int          exp_stall;
  } exp_t;
  exp_t sb[$];

  task automatic model_req(input bit wr, input logic [31:0] a, input logic [31:0] d, output exp_t e);
    int unsigned w = a >> 2;
    int s = int'(a[7:2]);
    int pos = -1;
    bit hit;
    for (int i = 0; i < lines[s].size(); i++) if (lines[s][i] == w) pos = i;
    hit = CACHE_ON && (pos >= 0);
    e.addr = a;
    if (hit) begin
      lines[s].delete(pos);
      lines[s].push_front(w);
    end
    if (wr) begin
      e.is_read = 1'b0; e.data = d; e.exp_rd = 1'b0; e.exp_wr = 1'b1; e.exp_stall = 5;
      ref_mem[w] = d;
    end else begin
      e.is_read = 1'b1; e.data = ref_read(w); e.exp_rd = !hit; e.exp_wr = 1'b0;
      e.exp_stall = hit ? 0 : 5;
      if (!hit && CACHE_ON) begin
        if (lines[s].size() == 2) void'(lines[s].pop_back());
        lines[s].push_front(w);
      end
    end
  endtask

  // Monitor: pops one expectation whenever a request completes (ready with a request held).
  int   stall = 0, done_cnt = 0;
  bit   saw_rd = 0, saw_wr = 0, mon_en = 1;
  exp_t mon_e;
  always @(negedge clk) begin
    #1;
    if (!rst || !mon_en) begin
      stall = 0; saw_rd = 0; saw_wr = 0;
    end else begin
      check("enables_exclusive", {31'b0, sram_rd_en & sram_wr_en}, 32'd0);
      if (rd_en || wr_en) begin
        saw_rd |= sram_rd_en;
        saw_wr |= sram_wr_en;
        if (ready) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_completion: got completion at t=%0t, expected none", $time);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_read) check("rdata", rdata, mon_e.data);
            else check("sram_wdata", sram_wdata, mon_e.data);
            if (mon_e.exp_rd || mon_e.exp_wr) check("sram_address", sram_address, mon_e.addr);
            check("stall_cycles", stall, mon_e.exp_stall);
            check("sram_rd_used", {31'b0, saw_rd}, {31'b0, mon_e.exp_rd});
            check("sram_wr_used", {31'b0, saw_wr}, {31'b0, mon_e.exp_wr});
          end
          stall = 0; saw_rd = 0; saw_wr = 0;
          done_cnt++;
        end else stall++;
      end else begin
        check("idle_ready", {31'b0, ready}, 32'd1);
        check("idle_enables", {30'b0, sram_rd_en, sram_wr_en}, 32'd0);
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int start, cyc;
    @(posedge clk); #1;
    model_req(wr, a, d, e);
    sb.push_back(e);
    rd_en = rd; wr_en = wr; address = a; wdata = d;
    start = done_cnt;
    cyc = 0;
    while (done_cnt == start && cyc < 50) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (done_cnt == start) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: request %h got no completion, expected one within 50 cycles", a);
      sb.delete();
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int s = 0; s < 64; s++) lines[s].delete();
  endtask

  initial begin
    sram_mem[32'h400 >> 2] = 32'hDEADBEEF;
    ref_mem[32'h400 >> 2]  = 32'hDEADBEEF;
    #2;
    check("reset_ready", {31'b0, ready}, 32'd1);
    check("reset_sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
    check("reset_sram_wr_en", {31'b0, sram_wr_en}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    do_req(1, 0, 32'h400, 0);
    do_req(1, 0, 32'h400, 0);
    do_req(1, 0, 32'h500, 0);
    do_req(1, 0, 32'h400, 0);
    do_req(1, 0, 32'h600, 0);
    do_req(1, 0, 32'h400, 0);
    do_req(1, 0, 32'h500, 0);
    idle_cycle();
    do_req(0, 1, 32'h400, 32'h12345678);
    do_req(1, 0, 32'h400, 0);
    do_req(0, 1, 32'h700, 32'hCAFEF00D);
    do_req(1, 0, 32'h700, 0);
    do_req(1, 1, 32'h400, 32'hA5A55A5A);
    do_req(1, 0, 32'h400, 0);
    idle_cycle();

    // Reset in the middle of a read miss aborts it without filling.
    mon_en = 0;
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'h800;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0; rd_en = 1'b0;
    #1;
    check("abort_sram_rd_en", {31'b0, sram_rd_en}, 32'd0);
    check("abort_sram_wr_en", {31'b0, sram_wr_en}, 32'd0);
    check("abort_ready", {31'b0, ready}, 32'd1);
    clear_model();
    @(posedge clk); #1 rst = 1'b1;
    mon_en = 1;
    do_req(1, 0, 32'h800, 0);
    do_req(1, 0, 32'h400, 0);
    idle_cycle();

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int op;
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op <= 5)      do_req(1, 0, a, 0);
      else if (op <= 8) do_req(0, 1, a, $urandom);
      else              do_req(1, 1, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    repeat (2) @(posedge clk);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
